digital_signal_generate: RTL and testbench

- Programmable rectangular-wave/PWM generator; the transmit counterpart of the digital signal measurement block.
- Drives one output pin with a programmed high time and low time, in clock cycles, for N periods or continuously.
- Sits in the logic-analyzer/signal-IO subsystem. Its output can be looped back into the measurement block for self-test.

---
 rtl/signal_gen_pkg.sv | 28 ++
 rtl/digital_signal_generate_if.sv | 29 ++
 rtl/gen_phase_counter.sv | 36 +++
 rtl/digital_signal_generate.sv | 172 +++++++++++++++++
 tb/tb_digital_signal_generate.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/signal_gen_pkg.sv
// Shared definitions for the rectangular-wave / PWM generator.
//   gen_state_e  : generator FSM states
//   timing_cfg_t : one complete timing configuration {high, low, count}
//   first_phase  : selects the first phase of a period from the high time
package signal_gen_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int PCNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } gen_state_e;

  typedef struct packed {
    logic [CNT_W_DEF-1:0]  high;
    logic [CNT_W_DEF-1:0]  low;
    logic [PCNT_W_DEF-1:0] count;
  } timing_cfg_t;

  // A period starts in LOW only when its high time is zero.
  function automatic gen_state_e first_phase(input logic high_is_zero);
    return high_is_zero ? LOW : HIGH;
  endfunction

endpackage

// File: rtl/digital_signal_generate_if.sv
// Control/status bundle of the signal generator.
//   master : controller side (drives start/stop and timing, reads status)
//   slave  : generator side
interface digital_signal_generate_if #(
  parameter int CNT_W  = 16,
  parameter int PCNT_W = 16
);
  logic              gen_start;
  logic              gen_stop;
  logic [CNT_W-1:0]  high_time;
  logic [CNT_W-1:0]  low_time;
  logic [PCNT_W-1:0] pulse_count;
  logic              gen_pin;
  logic              busy;
  logic              period_tick;
  logic [PCNT_W-1:0] periods_done;
  logic              gen_done;
  logic              cfg_err;

  modport master (
    output gen_start, gen_stop, high_time, low_time, pulse_count,
    input  gen_pin, busy, period_tick, periods_done, gen_done, cfg_err
  );

  modport slave (
    input  gen_start, gen_stop, high_time, low_time, pulse_count,
    output gen_pin, busy, period_tick, periods_done, gen_done, cfg_err
  );
endinterface

// File: rtl/gen_phase_counter.sv
// Phase counter for the signal generator.
//   clk, rst : clock and synchronous active-high reset
//   clr      : force count to 0 (has priority over en)
//   en       : count up by one
//   term     : terminal value (phase length - 1)
//   at_term  : count equals term
// Counting stops at term because the owner clears on at_term, so the
// counter never wraps.
module gen_phase_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         at_term
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + ONE;
    end
  end

  assign at_term = (cnt == term);

endmodule

// File: rtl/digital_signal_generate.sv
// Programmable rectangular-wave / PWM generator.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of digital_signal_generate_if
//              in : gen_start, gen_stop, high_time, low_time, pulse_count
//              out: gen_pin, busy, period_tick, periods_done, gen_done, cfg_err
//
// state | meaning
// IDLE  | waiting for gen_start
// HIGH  | high phase, gen_pin = 1
// LOW   | low phase, gen_pin = 0
// DONE  | one-cycle end marker, gen_done = 1
module digital_signal_generate
  import signal_gen_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PCNT_W = PCNT_W_DEF
) (
  input logic                      clk,
  input logic                      rst,
  digital_signal_generate_if.slave bus
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);

  gen_state_e        state, state_nxt;
  logic [CNT_W-1:0]  high_sh, low_sh;
  logic [PCNT_W-1:0] count_sh;
  logic [PCNT_W-1:0] periods_done_q;
  logic [PCNT_W-1:0] periods_inc;
  logic              stop_pend;
  logic              gen_pin_q;
  logic              cfg_err_q;

  logic              busy_s;
  logic              at_term;
  logic [CNT_W-1:0]  term_val;
  logic              period_end;
  logic              last_period;
  logic              stop_eff;
  logic              start_req;
  logic              start_bad;
  logic              new_cfg_zero;
  logic              relatch;

  // ---------------------------------------------------------------
  // Datapath decode
  // ---------------------------------------------------------------
  always_comb begin
    busy_s       = (state == HIGH) || (state == LOW);
    term_val     = (state == HIGH) ? (high_sh - CNT_ONE) : (low_sh - CNT_ONE);
    period_end   = ((state == HIGH) && at_term && (low_sh == '0)) ||
                   ((state == LOW) && at_term);
    periods_inc  = periods_done_q + PCNT_ONE;
    last_period  = (count_sh != '0) && (periods_inc == count_sh);
    // A stop arriving in the last cycle of a period still ends that period.
    stop_eff     = stop_pend || bus.gen_stop;
    start_req    = (state == IDLE) && bus.gen_start;
    new_cfg_zero = (bus.high_time == '0) && (bus.low_time == '0);
    start_bad    = start_req && new_cfg_zero;
    relatch      = period_end && !last_period && !stop_eff;
  end

  gen_phase_counter #(
    .W (CNT_W)
  ) u_phase (
    .clk     (clk),
    .rst     (rst),
    .clr     (!busy_s || at_term),
    .en      (busy_s),
    .term    (term_val),
    .at_term (at_term)
  );

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gen_pin_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      gen_pin_q <= (state_nxt == HIGH);
    end
  end

  // ---------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------
  always_comb begin
    gen_state_e end_target;
    if (last_period || stop_eff || new_cfg_zero) begin
      end_target = DONE;
    end else begin
      end_target = first_phase(bus.high_time == '0);
    end

    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_req && !start_bad) begin
          state_nxt = first_phase(bus.high_time == '0);
        end
      end
      HIGH: begin
        if (at_term) begin
          state_nxt = (low_sh != '0) ? LOW : end_target;
        end
      end
      LOW: begin
        if (at_term) begin
          state_nxt = end_target;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Shadow configuration, period counter, stop request
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      high_sh        <= '0;
      low_sh         <= '0;
      count_sh       <= '0;
      periods_done_q <= '0;
      stop_pend      <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      cfg_err_q <= start_bad;

      // Times are only re-sampled at a period boundary so a period is
      // never a mix of old and new settings; the count stays fixed per run.
      if (start_req) begin
        high_sh  <= bus.high_time;
        low_sh   <= bus.low_time;
        count_sh <= bus.pulse_count;
      end else if (relatch) begin
        high_sh <= bus.high_time;
        low_sh  <= bus.low_time;
      end

      if (start_req && !start_bad) begin
        periods_done_q <= '0;
      end else if (period_end) begin
        periods_done_q <= periods_inc;
      end

      if (state_nxt == IDLE) begin
        stop_pend <= 1'b0;
      end else if (busy_s && bus.gen_stop) begin
        stop_pend <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------
  always_comb begin
    bus.gen_pin      = gen_pin_q;
    bus.busy         = busy_s;
    bus.period_tick  = period_end;
    bus.periods_done = periods_done_q;
    bus.gen_done     = (state == DONE);
    bus.cfg_err      = cfg_err_q;
  end

endmodule

// File: tb/tb_digital_signal_generate.sv
module tb_digital_signal_generate;
  import signal_gen_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  digital_signal_generate_if #(.CNT_W(16), .PCNT_W(16)) bus ();

  digital_signal_generate #(.CNT_W(16), .PCNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int h;
    int l;
    int c;
    int stop_at;       // cycle in which gen_stop is held; 0 = never
    bit stop_w_start;  // gen_stop together with gen_start in IDLE
    int exp_done;      // cycle of the gen_done pulse
    int exp_hi;        // cycles with gen_pin = 1
    int exp_ticks;
    int exp_pd;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int h, input int l, input int c);
    timing_cfg_t t;
    t.high  = 16'(h);
    t.low   = 16'(l);
    t.count = 16'(c);
    bus.high_time   = t.high;
    bus.low_time    = t.low;
    bus.pulse_count = t.count;
  endtask

  task automatic do_start(input bit with_stop);
    bus.gen_start = 1'b1;
    bus.gen_stop  = with_stop;
    tick();
    bus.gen_start = 1'b0;
    bus.gen_stop  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int done_at = 0;
    int hi = 0;
    int ticks = 0;
    int dones = 0;
    set_cfg(v.h, v.l, v.c);
    do_start(v.stop_w_start);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (bus.gen_pin) hi++;
      if (bus.period_tick) ticks++;
      if (bus.gen_done) begin
        dones++;
        if (done_at == 0) done_at = cyc;
      end
      if (done_at != 0 && cyc >= done_at + 3) break;
      if (cyc == v.stop_at) bus.gen_stop = 1'b1;
      tick();
      bus.gen_stop = 1'b0;
    end
    chk($sformatf("vec%0d done_cycle", idx), done_at, v.exp_done);
    chk($sformatf("vec%0d high_cycles", idx), hi, v.exp_hi);
    chk($sformatf("vec%0d ticks", idx), ticks, v.exp_ticks);
    chk($sformatf("vec%0d done_pulses", idx), dones, 1);
    chk($sformatf("vec%0d periods_done", idx), bus.periods_done, v.exp_pd);
    chk($sformatf("vec%0d busy_after", idx), bus.busy, 0);
  endtask

  // Reference: the whole run as a list of periods of h ones followed by
  // l zeros, the last cycle of each carrying a tick, then one done cycle.
  task automatic build_model(input int h, input int l, input int c, input int stop_at,
                             output logic [3:0] q[$], output int nper);
    int p = h + l;
    nper = c;
    if (stop_at > 0) begin
      int k = (stop_at + p - 1) / p;
      if (nper == 0 || k < nper) nper = k;
    end
    q = {};
    for (int n = 0; n < nper; n++)
      for (int i = 0; i < p; i++)
        q.push_back({(i < h) ? 1'b1 : 1'b0, (i == p - 1) ? 1'b1 : 1'b0, 1'b0, 1'b1});
    q.push_back(4'b0010);
    q.push_back(4'b0000);
    q.push_back(4'b0000);
  endtask

  initial begin
    logic [3:0] exp_q[$];
    int nper;

    rst = 1'b1;
    bus.gen_start = 1'b0;
    bus.gen_stop  = 1'b0;
    set_cfg(0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    chk("reset_outputs",
        {bus.gen_pin, bus.busy, bus.period_tick, bus.gen_done, bus.cfg_err, bus.periods_done}, 0);

    // Rejected start: both times zero.
    set_cfg(0, 0, 5);
    do_start(1'b0);
    chk("cfg_err_pulse", bus.cfg_err, 1);
    chk("cfg_err_busy", bus.busy, 0);
    chk("cfg_err_pin", bus.gen_pin, 0);
    tick();
    chk("cfg_err_one_cycle", bus.cfg_err, 0);
    chk("cfg_err_still_idle", {bus.busy, bus.gen_pin}, 0);

    // Reset in the middle of a HIGH phase.
    set_cfg(2, 1, 0);
    do_start(1'b0);
    for (int cyc = 1; cyc < 7; cyc++) tick();
    chk("pre_reset_periods", bus.periods_done, 2);
    chk("pre_reset_pin", bus.gen_pin, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_reset_state",
        {bus.gen_pin, bus.busy, bus.period_tick, bus.gen_done, bus.periods_done}, 0);

    vecs[0] = '{3, 2, 4, 0, 1'b0, 21, 12, 4, 4};
    vecs[1] = '{5, 0, 2, 0, 1'b0, 11, 10, 2, 2};
    vecs[2] = '{0, 3, 2, 0, 1'b0,  7,  0, 2, 2};
    vecs[3] = '{1, 1, 1, 0, 1'b0,  3,  1, 1, 1};
    vecs[4] = '{2, 3, 0, 7, 1'b0, 11,  4, 2, 2};
    vecs[5] = '{2, 2, 3, 1, 1'b0,  5,  2, 1, 1};
    vecs[6] = '{1, 0, 3, 0, 1'b0,  4,  3, 3, 3};
    vecs[7] = '{4, 4, 1, 8, 1'b0,  9,  4, 1, 1};
    vecs[8] = '{2, 1, 2, 0, 1'b1,  7,  4, 2, 2};
    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Continuous 4/4, new 2/6 applied mid-period 2, ignored start, stop at 18.
    set_cfg(4, 4, 0);
    do_start(1'b0);
    for (int cyc = 1; cyc <= 28; cyc++) begin
      logic ep, et, ed;
      ep = (cyc >= 1 && cyc <= 4) || (cyc >= 9 && cyc <= 12) || (cyc >= 17 && cyc <= 18);
      et = (cyc == 8) || (cyc == 16) || (cyc == 24);
      ed = (cyc == 25);
      chk($sformatf("relatch_cyc%0d", cyc), {bus.gen_pin, bus.period_tick, bus.gen_done},
          {ep, et, ed});
      if (cyc == 10) set_cfg(2, 6, 0);
      if (cyc == 12) bus.gen_start = 1'b1;
      if (cyc == 18) bus.gen_stop = 1'b1;
      tick();
      bus.gen_start = 1'b0;
      bus.gen_stop  = 1'b0;
    end
    chk("relatch_periods", bus.periods_done, 3);

    // 100/300 continuous: check what a measurement block would see.
    begin
      int t1 = 0, t2 = 0, hi2 = 0, done_seen = 0;
      set_cfg(100, 300, 0);
      do_start(1'b0);
      for (int cyc = 1; cyc <= 820; cyc++) begin
        if (bus.period_tick) begin
          if (t1 == 0) t1 = cyc;
          else if (t2 == 0) t2 = cyc;
        end
        if (cyc > 400 && cyc <= 800 && bus.gen_pin) hi2++;
        if (cyc == 810) bus.gen_stop = 1'b1;
        tick();
        bus.gen_stop = 1'b0;
      end
      for (int k = 0; k < 500 && !done_seen; k++) begin
        if (bus.gen_done) done_seen = 1;
        else tick();
      end
      tick();
      chk("loop_high", hi2, 100);
      chk("loop_low", 400 - hi2, 300);
      chk("loop_period", t2 - t1, 400);
      chk("loop_duty", (hi2 * 100) / (t2 - t1), 25);
      chk("loop_stopped", done_seen, 1);
    end

    // Randomized runs against the period-list model.
    for (int r = 0; r < 25; r++) begin
      int h, l, c, p, stop_at, start_at;
      h = $urandom_range(0, 5);
      l = $urandom_range(0, 5);
      if (h == 0 && l == 0) l = 1;
      p = h + l;
      c = $urandom_range(0, 4);
      if (c == 0) stop_at = $urandom_range(1, 3 * p);
      else if ($urandom_range(0, 1) == 1) stop_at = $urandom_range(1, c * p);
      else stop_at = 0;
      build_model(h, l, c, stop_at, exp_q, nper);
      start_at = $urandom_range(1, nper * p + 1);
      set_cfg(h, l, c);
      do_start(1'b0);
      for (int cyc = 1; cyc <= exp_q.size(); cyc++) begin
        chk($sformatf("rand%0d_cyc%0d", r, cyc),
            {bus.gen_pin, bus.period_tick, bus.gen_done, bus.busy}, exp_q[cyc-1]);
        if (cyc == stop_at) bus.gen_stop = 1'b1;
        if (cyc == start_at) bus.gen_start = 1'b1;
        tick();
        bus.gen_stop  = 1'b0;
        bus.gen_start = 1'b0;
      end
      chk($sformatf("rand%0d_periods", r), bus.periods_done, nper);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
